// File: rtl/bill_cart_scanner.sv
// bill_cart_scanner
// Sequential front end for the bill amount generator. Collects one item scan
// per clock into five saturating 4-bit per-product quantities, freezes them on
// checkout for the combinational bill block, and clears them on bill_ack.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   scan_valid   scan qualifier, sampled every rising edge
//   scan_id      product code (1..5 valid, 0/6/7 invalid)
//   scan_remove  with scan_valid: 1 removes one item, 0 adds one
//   checkout     request to freeze the cart
//   bill_ack     bill consumed; clears the cart while locked
//   q1..q5       registered per-product quantities
//   item_count   registered sum of q1..q5 (0..75)
//   bill_valid   quantities frozen and valid for billing
//   scan_ok      one-cycle pulse: previous-cycle scan was applied
//   err          one-cycle pulse: previous-cycle request was rejected
//   err_code     qualified by err: 1 bad id, 2 saturation/underflow,
//                3 locked or empty checkout (0 when err is low)
//   state_dbg    current FSM state (0 IDLE, 1 SHOP, 2 LOCK)
//
// Handshake: there is no backpressure. Every cycle with scan_valid high is one
// scan request, consumed at that rising edge; its outcome appears as exactly
// one of scan_ok / err during the following cycle. checkout and bill_ack are
// level requests sampled at the same edge.
module bill_cart_scanner #(
  parameter int NPROD = 5,
  parameter int QMAX  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [2:0] scan_id,
  input  logic       scan_remove,
  input  logic       checkout,
  input  logic       bill_ack,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic [3:0] q4,
  output logic [3:0] q5,
  output logic [6:0] item_count,
  output logic       bill_valid,
  output logic       scan_ok,
  output logic       err,
  output logic [1:0] err_code,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOP = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] q_r [NPROD];
  logic [3:0] q_n [NPROD];
  logic [6:0] count_n;
  logic       bill_valid_n;
  logic       scan_ok_n;
  logic       err_n;
  logic [1:0] err_code_n;

  logic             id_ok;
  logic [NPROD-1:0] hit;
  logic [3:0]       sel_q;

  // One-hot decode of the product code; an invalid id selects nothing.
  always_comb begin
    id_ok = (scan_id >= 3'd1) && (scan_id <= 3'd5);
    hit   = '0;
    sel_q = '0;
    for (int i = 0; i < NPROD; i++) begin
      hit[i] = id_ok && (scan_id == 3'(i + 1));
      if (hit[i]) sel_q = q_r[i];
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = item_count;
    scan_ok_n  = 1'b0;
    err_n      = 1'b0;
    err_code_n = 2'd0;
    for (int i = 0; i < NPROD; i++) q_n[i] = q_r[i];

    if (state == LOCK) begin
      // Cart is frozen: scans always bounce, checkout is a silent no-op.
      if (scan_valid) begin
        err_n      = 1'b1;
        err_code_n = 2'd3;
      end
      if (bill_ack) begin
        for (int i = 0; i < NPROD; i++) q_n[i] = '0;
        count_n = '0;
        state_n = IDLE;
      end
    end else begin
      // The id check comes before the saturation/underflow check.
      if (scan_valid) begin
        if (!id_ok) begin
          err_n      = 1'b1;
          err_code_n = 2'd1;
        end else if (scan_remove) begin
          if (sel_q == 4'd0) begin
            err_n      = 1'b1;
            err_code_n = 2'd2;
          end else begin
            for (int i = 0; i < NPROD; i++)
              if (hit[i]) q_n[i] = q_r[i] - 4'd1;
            count_n   = item_count - 7'd1;
            scan_ok_n = 1'b1;
          end
        end else begin
          if (sel_q == 4'(QMAX)) begin
            err_n      = 1'b1;
            err_code_n = 2'd2;
          end else begin
            for (int i = 0; i < NPROD; i++)
              if (hit[i]) q_n[i] = q_r[i] + 4'd1;
            count_n   = item_count + 7'd1;
            scan_ok_n = 1'b1;
          end
        end
      end

      // Checkout acts on the post-scan count. An empty checkout reports
      // code 3 unless the same-cycle scan already reported its own error;
      // a scan that emptied the cart yields err only, never scan_ok with it.
      if (checkout) begin
        if (count_n != 7'd0) begin
          state_n = LOCK;
        end else begin
          state_n = IDLE;
          if (!err_n) begin
            scan_ok_n  = 1'b0;
            err_n      = 1'b1;
            err_code_n = 2'd3;
          end
        end
      end else begin
        state_n = (count_n != 7'd0) ? SHOP : IDLE;
      end
    end

    bill_valid_n = (state_n == LOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPROD; i++) q_r[i] <= '0;
      item_count <= '0;
      bill_valid <= 1'b0;
      scan_ok    <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      for (int i = 0; i < NPROD; i++) q_r[i] <= q_n[i];
      item_count <= count_n;
      bill_valid <= bill_valid_n;
      scan_ok    <= scan_ok_n;
      err        <= err_n;
      err_code   <= err_code_n;
    end
  end

  assign q1        = q_r[0];
  assign q2        = q_r[1];
  assign q3        = q_r[2];
  assign q4        = q_r[3];
  assign q5        = q_r[4];
  assign state_dbg = state;

endmodule

// File: doc/bill_cart_scanner.md
Name: bill_cart_scanner

Overview:
Sequential front end for the bill amount generator. It collects item scans one per clock from a checkout counter and keeps one 4-bit quantity per product (five products). On checkout it freezes the quantities and presents them to the combinational bill block, which turns q1..q5 into total, ed, discount and final. It holds them until the bill is acknowledged.

Parameters:
NPROD, 5, number of products; fixed at 5 to match the bill block's q1..q5 inputs.
QMAX, 15, saturation value of each quantity (4-bit limit).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
scan_valid  input  1  scan event qualifier, sampled each rising edge
scan_id  input  3  product code; 1..5 are valid, 0/6/7 are invalid
scan_remove  input  1  with scan_valid: 1 removes one item, 0 adds one
checkout  input  1  request to freeze the cart
bill_ack  input  1  bill consumed; clear the cart
q1,q2,q3,q4,q5  output  4 each  registered per-product quantities, to bill block
item_count  output  7  registered sum of q1..q5 (0..75)
bill_valid  output  1  quantities frozen and valid for billing
scan_ok  output  1  one-cycle pulse: the previous-cycle scan was applied
err  output  1  one-cycle pulse: the previous-cycle request was rejected
err_code  output  2  qualified by err: 1 = bad id, 2 = saturation/underflow, 3 = locked or empty checkout

Behaviour:
- Reset (async, immediate): all q = 0, item_count = 0, bill_valid = 0, scan_ok = 0, err = 0, err_code = 0, state = IDLE.
- States:
  - IDLE: item_count == 0.
  - SHOP: item_count > 0.
  - LOCK: bill_valid = 1.
- Scan processing in IDLE/SHOP:
  - A scan sampled on edge N updates q, item_count and the state at edge N.
  - scan_ok or err is registered and visible for exactly the cycle after edge N.
- Add: if q[id] < 15, then q[id]+1 and item_count+1. At 15 the scan is rejected with err_code 2 and no change.
- Remove: if q[id] > 0, then q[id]-1 and item_count-1. At 0 the scan is rejected with err_code 2.
- Invalid scan_id: reject with err_code 1, no change. The id check precedes the saturation check.
- Transitions:
  - IDLE->SHOP on the first applied add.
  - SHOP->IDLE when a remove brings item_count to 0.
- checkout in SHOP:
  - A scan in the same cycle is applied first.
  - If the post-scan item_count > 0: go to LOCK and set bill_valid = 1 at that edge.
  - If the same-cycle scan is rejected: err_code 1/2 wins and the lock still occurs.
  - If the post-scan count is 0: go to IDLE and raise err_code 3.
- checkout in IDLE: err_code 3, stay in IDLE. A same-cycle add is applied and then locks, following the SHOP rule.
- LOCK:
  - q and item_count are held constant.
  - scan_valid is rejected with err_code 3.
  - checkout is ignored silently.
- bill_ack in LOCK: at that edge all q = 0, item_count = 0, bill_valid = 0, state goes to IDLE. A same-cycle scan is rejected (err_code 3).
- bill_ack outside LOCK: ignored.
- scan_ok and err are never high together. Each pulse is one cycle wide. Back-to-back scans on consecutive cycles are all processed, one per cycle.
- Width rules: item_count is 7-bit and never exceeds 75. No arithmetic wrap is permitted on any q.
- Reset mid-operation, including in LOCK, clears everything immediately. bill_valid drops asynchronously.

Test Plan:
- Reset, then add ids 1,1,3,5 on consecutive cycles -> four scan_ok pulses; q1=2, q3=1, q5=1, item_count=4, state SHOP. Checkout -> bill_valid=1, and the bill block shows total=320.
- Add id 2 sixteen times -> first 15 give scan_ok, q2=15; the 16th gives err with err_code=2 and q2 stays 15. Then remove id 4 at q4=0 -> err_code=2.
- scan_id=0, then 6, then 7 -> err_code=1 each time, all q remain 0. Checkout in IDLE -> err_code=3 and bill_valid stays 0.
- In LOCK, add id 1 -> err_code=3 and q unchanged. bill_ack -> next cycle all q=0, item_count=0, bill_valid=0. A scan in the following cycle is accepted.
- Same-cycle cases:
  - In SHOP with q4=1 only: remove id 4 together with checkout -> q4=0, IDLE, err_code=3.
  - Add id 4 together with checkout from IDLE -> q4=1 and LOCK.
- Assert rst asynchronously mid-cycle while in LOCK with q3=9 -> outputs go to 0 before the next edge. Normal scanning resumes after rst is released.
